// File: rtl/gate_response_checker.sv
// Self-test sequencer for a combinational 2-input gate: walks {a,b} through 00..11,
// samples y after SETTLE cycles per vector and compares against EXPECT.
// Define GATE_CHK_FAIL_CAPTURE_EN to record the first failing vector on fail_vec.
module gate_response_checker #(
   parameter logic [3:0]  EXPECT = 4'b0001,
   parameter int unsigned SETTLE = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       y,
   output logic       a_o,
   output logic       b_o,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_cnt,
   output logic [1:0] fail_vec
);

   typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

   state_t     state;
   state_t     state_nxt;
   logic [1:0] vec;
   logic [3:0] cnt;
   logic       mismatch;
   logic [2:0] err_nxt;

   assign mismatch = (y != EXPECT[vec]);

   // Next-state logic and the error count as it will stand after a CHECK edge
   always_comb begin
      state_nxt = state;
      err_nxt   = err_cnt;
      case (state)
         IDLE:  if (start) state_nxt = APPLY;
         APPLY: if (cnt == SETTLE_LAST) state_nxt = CHECK;
         CHECK: begin
            if (mismatch && err_cnt != 3'd4) err_nxt = err_cnt + 3'd1;
            state_nxt = (vec == 2'd3) ? DONE : APPLY;
         end
         DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // busy and done are registered from the next state so they line up with the state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         pass    <= 1'b0;
         err_cnt <= 3'd0;
         vec     <= 2'd0;
         cnt     <= 4'd0;
         a_o     <= 1'b0;
         b_o     <= 1'b0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt != IDLE);
         done  <= (state_nxt == DONE);
         case (state)
            IDLE: begin
               if (start) begin
                  vec        <= 2'd0;
                  cnt        <= 4'd0;
                  {a_o, b_o} <= 2'b00;
                  err_cnt    <= 3'd0;
                  pass       <= 1'b0;
               end
            end
            APPLY: begin
               if (cnt != SETTLE_LAST) cnt <= cnt + 4'd1;
            end
            CHECK: begin
               err_cnt <= err_nxt;
               if (vec == 2'd3) begin
                  pass <= (err_nxt == 3'd0);
               end else begin
                  vec        <= vec + 2'd1;
                  {a_o, b_o} <= vec + 2'd1;
                  cnt        <= 4'd0;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef GATE_CHK_FAIL_CAPTURE_EN
   // A zero error count at a mismatch means this is the first failure of the run
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         fail_vec <= 2'b00;
      else if (state == IDLE && start)
         fail_vec <= 2'b00;
      else if (state == CHECK && mismatch && err_cnt == 3'd0)
         fail_vec <= vec;
   end
`else
   assign fail_vec = 2'b00;
`endif

endmodule

// File: tb/tb_gate_response_checker.sv
// Self-checking bench for gate_response_checker: drives several gate models through
// full check sequences and scores the results via an expectation queue.
module tb_gate_response_checker;

   localparam logic [3:0] EXPECT_TB = 4'b0001;

   typedef struct {
      logic [2:0] err;
      logic       pass;
      logic [1:0] fv;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   bit   sel = 1'b0;
   int   gate_mode = 0;

   logic       a0, b0, busy0, done0, pass0, y0;
   logic [2:0] err0;
   logic [1:0] fv0;
   logic       a1, b1, busy1, done1, pass1, y1;
   logic [2:0] err1;
   logic [1:0] fv1;

   logic       obs_a, obs_b, obs_busy, obs_done, obs_pass;
   logic [2:0] obs_err;
   logic [1:0] obs_fv;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   // Gate models: 0 NOR, 1 stuck-at-0, 2 stuck-at-1, 3 AND
   function automatic logic gateY(input int m, input logic a, input logic b);
      case (m)
         0: return ~(a | b);
         1: return 1'b0;
         2: return 1'b1;
         default: return a & b;
      endcase
   endfunction

   always #5 clk = ~clk;

   assign y0 = gateY(gate_mode, a0, b0);
   assign y1 = ~(a1 | b1);

   gate_response_checker dut0 (
      .clk(clk), .rst_n(rst_n), .start(start & ~sel), .y(y0),
      .a_o(a0), .b_o(b0), .busy(busy0), .done(done0), .pass(pass0),
      .err_cnt(err0), .fail_vec(fv0)
   );

   gate_response_checker #(.EXPECT(4'b0001), .SETTLE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start & sel), .y(y1),
      .a_o(a1), .b_o(b1), .busy(busy1), .done(done1), .pass(pass1),
      .err_cnt(err1), .fail_vec(fv1)
   );

   assign obs_a    = sel ? a1    : a0;
   assign obs_b    = sel ? b1    : b0;
   assign obs_busy = sel ? busy1 : busy0;
   assign obs_done = sel ? done1 : done0;
   assign obs_pass = sel ? pass1 : pass0;
   assign obs_err  = sel ? err1  : err0;
   assign obs_fv   = sel ? fv1   : fv0;

   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pulses start for one cycle; optionally queues the expected outcome from the model
   task automatic applyStimulus(input int mode, input bit push);
      exp_t e;
      logic ym;
      logic [1:0] v2;
      gate_mode = mode;
      if (push) begin
         e.err = 3'd0;
         e.fv  = 2'b00;
         for (int v = 0; v < 4; v++) begin
            v2 = 2'(v);
            ym = gateY(mode, v2[1], v2[0]);
            if (ym !== EXPECT_TB[v2]) begin
`ifdef GATE_CHK_FAIL_CAPTURE_EN
               if (e.err == 3'd0) e.fv = v2;
`endif
               e.err = e.err + 3'd1;
            end
         end
         e.pass = (e.err == 3'd0);
         sb.push_back(e);
      end
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   // Follows a run from just after edge 0 until done, then scores it
   task automatic followSequence(input bit inject);
      int   settle;
      int   cyc;
      exp_t e;
      settle = sel ? 1 : 2;
      cyc = 0;
      while (obs_done !== 1'b1 && cyc < 40) begin
         if (cyc % (settle + 1) == 1)
            checkOutput("vector", 16'({obs_a, obs_b}), 16'(cyc / (settle + 1)));
         if (inject) begin
            checkOutput("busy_hold", 16'(obs_busy), 16'd1);
            start = (cyc == 3 || cyc == 11);
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      checkOutput("done_seen", 16'(obs_done), 16'd1);
      checkOutput("done_cycle", 16'(cyc), 16'(4 * (settle + 1)));
      if (sb.size() > 0) begin
         e = sb.pop_front();
      end else begin
         checks++;
         errors++;
         $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
         e.err = 3'd0; e.pass = 1'b1; e.fv = 2'b00;
      end
      checkOutput("err_cnt", 16'(obs_err), 16'(e.err));
      checkOutput("pass", 16'(obs_pass), 16'(e.pass));
      checkOutput("fail_vec", 16'(obs_fv), 16'(e.fv));
      checkOutput("busy_in_done", 16'(obs_busy), 16'd1);
      @(negedge clk);
      checkOutput("done_pulse_end", 16'(obs_done), 16'd0);
      checkOutput("busy_cleared", 16'(obs_busy), 16'd0);
      checkOutput("ab_hold_11", 16'({obs_a, obs_b}), 16'd3);
      checkOutput("err_held", 16'(obs_err), 16'(e.err));
      checkOutput("pass_held", 16'(obs_pass), 16'(e.pass));
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset_state", 16'({a0, b0, busy0, done0, pass0, err0, fv0}), 16'd0);
      rst_n = 1'b1;
      @(negedge clk);

      applyStimulus(0, 1'b1); followSequence(1'b0);
      applyStimulus(1, 1'b1); followSequence(1'b0);
      applyStimulus(2, 1'b1); followSequence(1'b0);
      applyStimulus(3, 1'b1); followSequence(1'b0);

      // Extra start pulses at edges 4 and 12 must be ignored
      applyStimulus(0, 1'b1); followSequence(1'b1);

      // Asynchronous reset between edges 6 and 7 of a run
      applyStimulus(0, 1'b0);
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset", 16'({a0, b0, busy0, done0, pass0, err0, fv0}), 16'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("no_done_in_reset", 16'(done0), 16'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("idle_after_reset", 16'(busy0), 16'd0);
      applyStimulus(2, 1'b1); followSequence(1'b0);

      // SETTLE=1 instance
      sel = 1'b1;
      applyStimulus(0, 1'b1); followSequence(1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
